dzcpu_useq: RTL
===============

Name: dzcpu_useq

Overview:
Microcode sequencer for the dzcpu core. It fetches each opcode byte and steps the micro-op address through the opcode's flow in the microcode ROM. It handles the 0xCB prefix hop and conditional early termination. It also handles interrupt entry, stalls on memory wait, and enforces a flow-length watchdog. It sits between the memory data bus, the opcode/CB lookup tables and the microcode ROM; its outputs drive the PC-increment and flag-update strobes of the datapath.

Parameters:
UADDR_W, 8, width of micro-op address and lookup-table indices
INT_FLOW_IDX, 8'd175, micro-op address of the interrupt-entry flow
MAX_FLOW_LEN, 32, maximum micro-ops executed per instruction before the watchdog fires (range 2..255)

Ports:
iClock  in  1  core clock, all state on rising edge
iReset  in  1  synchronous, active-high reset
iMop  in  8  memory read data (opcode / CB byte at PC)
iMemWait  in  1  memory not ready this cycle
iUopFlow  in  3  flow field of current ROM word: 0 op, 1 inc, 2 eof, 3 inc_eof, 4 inc_eof_z, 5 inc_eof_nz, 6 eof_fu, 7 inc_eof_fu
iUopJcb  in  1  current micro-op is jcb (CB prefix hop)
iUopMem  in  1  current micro-op accesses memory (srm/smw)
iFlagZ  in  1  current Z flag
iIme  in  1  interrupt master enable
iIntReq  in  1  any enabled interrupt pending
iLutIdx  in  UADDR_W  main lookup table result for oMop
iCbLutIdx  in  UADDR_W  CB lookup table result for oMop
oMop  out  8  latched opcode, drives both lookup tables
oUopAddr  out  UADDR_W  micro-op ROM address
oUopValid  out  1  micro-op at oUopAddr executes this cycle
oPcInc  out  1  PC increment strobe
oFlagsUpdate  out  1  flag commit strobe
oIntAck  out  1  one-cycle interrupt acknowledge
oInstrDone  out  1  one-cycle pulse when a flow terminates
oSeqErr  out  1  sticky watchdog error

Behaviour:
- States: S_FETCH, S_DISPATCH, S_EXEC, S_CBFETCH, S_CBDISPATCH, S_INT.
- Reset: state=S_FETCH, oMop=0, oUopAddr=0, flow counter=0, oSeqErr=0. All strobes are 0 during and after reset until a micro-op executes.
- A reset asserted mid-flow abandons the flow; no strobes occur in the reset cycle.
- S_FETCH, iMemWait=1: hold.
- S_FETCH, iIme&iIntReq: go to S_INT; iMop is discarded; no oPcInc.
- S_FETCH, otherwise: latch oMop<=iMop; go to S_DISPATCH.
- S_DISPATCH: oUopAddr<=iLutIdx; counter<=0; go to S_EXEC. Opcode sampled to first micro-op executing takes 2 cycles.
- S_INT: oIntAck=1 for this cycle; oUopAddr<=INT_FLOW_IDX; counter<=0; go to S_EXEC.
- S_EXEC: oUopValid=1 unless (iMemWait & iUopMem). When oUopValid=0 the state, address and counter hold and all strobes are 0.
- On a valid micro-op: oPcInc=1 for flows 1,3,4,5,7.
- On a valid micro-op: oFlagsUpdate=1 for flows 6,7.
- Termination: flows 2,3,6,7 always terminate. Flow 4 terminates iff iFlagZ=1. Flow 5 terminates iff iFlagZ=0.
- A non-terminating conditional flow still pulses oPcInc and advances.
- On termination: oInstrDone=1; next state is S_FETCH.
- Else if iUopJcb: next state is S_CBFETCH. iUopJcb takes priority over advance.
- Else: oUopAddr<=oUopAddr+1; counter++.
- Address wrap: addr 255 increments to 0. This is allowed only if the watchdog has not fired.
- Watchdog: a valid non-terminating micro-op with counter==MAX_FLOW_LEN-1 forces S_FETCH, sets oSeqErr=1 and pulses oInstrDone. oSeqErr clears only on reset.
- S_CBFETCH: waits on iMemWait like S_FETCH, then latches oMop<=iMop. Interrupts are not sampled.
- S_CBDISPATCH: oUopAddr<=iCbLutIdx; counter keeps counting from the prefix flow; go to S_EXEC.
- Unmapped opcodes (LUT returns 0) execute flow 0 normally.

Test Plan:
- Reset, then 0x00 (NOP, LUT=162, flow 3) -> addr 162 for one cycle with oPcInc=1 and oInstrDone=1; back to S_FETCH 3 cycles after fetch.
- 0x31 (LUT=1, flows inc,inc,op,inc_eof) -> addresses 1,2,3,4 on consecutive cycles; oPcInc pattern 1,1,0,1; oInstrDone with addr 4.
- 0x20 (LUT=17) with iFlagZ=1 -> terminates at addr 19 with oPcInc=1. With iFlagZ=0 -> runs 19..22; oInstrDone at 22.
- 0xCB then 0x7C (LUT=13, CB LUT=16) -> addresses 13,14,15, then CB fetch/dispatch, then addr 16 with oFlagsUpdate=1 and oInstrDone=1.
- iIme=1, iIntReq=1 in S_FETCH -> oIntAck for 1 cycle, next addr 175, no oPcInc. With iIme=0 the opcode fetch proceeds normally.
- iMemWait=1 for 3 cycles on an iUopMem micro-op -> address frozen and oUopValid=0 for 3 cycles. Then a flow of 40 op micro-ops with MAX_FLOW_LEN=32 -> oSeqErr=1 after 32 micro-ops, return to S_FETCH, oSeqErr stays set until reset.

Source files
------------

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: opcode fetch, LUT dispatch, CB prefix hop,
// interrupt entry, memory-wait stalls and flow-length watchdog.
module dzcpu_useq #(
  parameter int                 UADDR_W      = 8,
  parameter logic [UADDR_W-1:0] INT_FLOW_IDX = 8'd175,
  parameter int                 MAX_FLOW_LEN = 32
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic [7:0]         iMop,
  input  logic               iMemWait,
  input  logic [2:0]         iUopFlow,
  input  logic               iUopJcb,
  input  logic               iUopMem,
  input  logic               iFlagZ,
  input  logic               iIme,
  input  logic               iIntReq,
  input  logic [UADDR_W-1:0] iLutIdx,
  input  logic [UADDR_W-1:0] iCbLutIdx,
  output logic [7:0]         oMop,
  output logic [UADDR_W-1:0] oUopAddr,
  output logic               oUopValid,
  output logic               oPcInc,
  output logic               oFlagsUpdate,
  output logic               oIntAck,
  output logic               oInstrDone,
  output logic               oSeqErr
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DISPATCH,
    S_EXEC,
    S_CBFETCH,
    S_CBDISPATCH,
    S_INT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_FLOW_LEN - 1);

  state_t             state_q, state_d;
  logic [7:0]         mop_q, mop_d;
  logic [UADDR_W-1:0] addr_q, addr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               err_q, err_d;

  logic valid, pc_inc, flags_upd, int_ack, done;
  logic term;

  always_comb begin
    pc_inc    = 1'b0;
    flags_upd = 1'b0;
    term      = 1'b0;
    unique case (iUopFlow)
      3'd0: term = 1'b0;
      3'd1: pc_inc = 1'b1;
      3'd2: term = 1'b1;
      3'd3: begin pc_inc = 1'b1; term = 1'b1; end
      3'd4: begin pc_inc = 1'b1; term = iFlagZ; end
      3'd5: begin pc_inc = 1'b1; term = ~iFlagZ; end
      3'd6: begin flags_upd = 1'b1; term = 1'b1; end
      3'd7: begin
        pc_inc    = 1'b1;
        flags_upd = 1'b1;
        term      = 1'b1;
      end
      default: term = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mop_d   = mop_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    valid   = 1'b0;
    int_ack = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (!iMemWait) begin
          if (iIme && iIntReq) begin
            state_d = S_INT;
          end else begin
            mop_d   = iMop;
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        addr_d  = iLutIdx;
        cnt_d   = 8'd0;
        state_d = S_EXEC;
      end
      S_INT: begin
        int_ack = 1'b1;
        addr_d  = INT_FLOW_IDX;
        cnt_d   = 8'd0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        valid = ~(iMemWait & iUopMem);
        if (valid) begin
          if (term) begin
            done    = 1'b1;
            state_d = S_FETCH;
          end else if (cnt_q == CNT_LAST) begin
            done    = 1'b1;
            err_d   = 1'b1;
            state_d = S_FETCH;
          end else if (iUopJcb) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = S_CBFETCH;
          end else begin
            addr_d = addr_q + UADDR_W'(1);
            cnt_d  = cnt_q + 8'd1;
          end
        end
      end
      S_CBFETCH: begin
        if (!iMemWait) begin
          mop_d   = iMop;
          state_d = S_CBDISPATCH;
        end
      end
      S_CBDISPATCH: begin
        addr_d  = iCbLutIdx;
        state_d = S_EXEC;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_FETCH;
      mop_q   <= 8'd0;
      addr_q  <= '0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mop_q   <= mop_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // strobes are suppressed in a reset cycle so an abandoned flow has no effect
  assign oUopValid    = valid & ~iReset;
  assign oPcInc       = valid & pc_inc & ~iReset;
  assign oFlagsUpdate = valid & flags_upd & ~iReset;
  assign oIntAck      = int_ack & ~iReset;
  assign oInstrDone   = done & ~iReset;
  assign oMop         = mop_q;
  assign oUopAddr     = addr_q;
  assign oSeqErr      = err_q;

endmodule
